// File: rtl/csr_access_ctrl_pkg.sv
// Shared definitions for the CSR access controller: funct3 encodings,
// FSM state encoding, latched request record and address/op helpers.
package csr_access_ctrl_pkg;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // Request fields captured at acceptance; bad_op marks an unknown funct3.
  typedef struct packed {
    logic [2:0]  funct3;
    logic [11:0] addr;
    logic [4:0]  rs1_idx;
    logic [31:0] rs1_val;
    logic [4:0]  rd_idx;
    logic        bad_op;
  } csr_req_t;

  // Addresses with [11:10] == 2'b11 are read-only CSRs.
  function automatic logic is_read_only(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

  // funct3 000 and 100 are not CSR ops; the low two bits select RW/RS/RC.
  function automatic logic is_legal_op(input logic [2:0] f3);
    return f3[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/csr_access_ctrl_modify.sv
// csr_modify: combinational read-modify-write value and write qualifier.
module csr_modify
  import csr_access_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] old,
  input  logic [31:0] operand,
  input  logic        rs1_zero,
  output logic [31:0] new_val,
  output logic        write_en
);

  // Set/clear forms skip the write when rs1 (or zimm) is x0; plain writes always write.
  always_comb begin
    new_val  = old;
    write_en = 1'b0;
    unique case (op[1:0])
      2'b01: begin
        new_val  = operand;
        write_en = 1'b1;
      end
      2'b10: begin
        new_val  = old | operand;
        write_en = !rs1_zero;
      end
      2'b11: begin
        new_val  = old & ~operand;
        write_en = !rs1_zero;
      end
      default: begin
        new_val  = old;
        write_en = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: sequences one CSR instruction through read (RD) and
// write-back (WB), driving the CSR file ports and the GPR writeback.
module csr_access_ctrl
  import csr_access_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  funct3,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  rs1_idx,
  input  logic [31:0] rs1_val,
  input  logic [4:0]  rd_idx,
  input  logic        freeze,
  output logic [11:0] csr_adr_rd,
  input  logic [31:0] csr_rddata,
  output logic [11:0] csr_adr_wr,
  output logic [31:0] csr_wrdata,
  output logic        csr_wr_en,
  output logic        rd_we,
  output logic [4:0]  rd_waddr,
  output logic [31:0] rd_wdata,
  output logic        illegal,
  output logic        busy
);

  state_e   state_q, state_d;
  csr_req_t req_q;
  logic     accept;
  logic [31:0] operand;
  logic [31:0] new_val;
  logic        mod_we;
  logic        ro_fault;

  assign req_ready  = (state_q == ST_IDLE) && !freeze;
  assign busy       = (state_q != ST_IDLE);
  assign accept     = req_valid && req_ready;
  assign csr_adr_rd = req_q.addr;

  // Immediate forms use the rs1 field itself, zero-extended, as the operand.
  assign operand  = req_q.funct3[2] ? {27'b0, req_q.rs1_idx} : req_q.rs1_val;
  assign ro_fault = mod_we && is_read_only(req_q.addr);

  csr_modify u_modify (
    .op       (req_q.funct3),
    .old      (csr_rddata),
    .operand  (operand),
    .rs1_zero (req_q.rs1_idx == 5'd0),
    .new_val  (new_val),
    .write_en (mod_we)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Capture the request on the accepting edge; fields stay stable until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= '0;
    end else if (accept) begin
      req_q.funct3  <= funct3;
      req_q.addr    <= csr_addr;
      req_q.rs1_idx <= rs1_idx;
      req_q.rs1_val <= rs1_val;
      req_q.rd_idx  <= rd_idx;
      req_q.bad_op  <= !is_legal_op(funct3);
    end
  end

  // Next state and pulse outputs; reset masks every pulse so an aborted access writes nothing.
  always_comb begin
    state_d    = state_q;
    csr_wr_en  = 1'b0;
    csr_adr_wr = '0;
    csr_wrdata = '0;
    rd_we      = 1'b0;
    rd_waddr   = '0;
    rd_wdata   = '0;
    illegal    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_RD;
      end
      ST_RD: begin
        if (req_q.bad_op) begin
          illegal = !rst;
          state_d = ST_IDLE;
        end else if (!freeze) begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        if (!freeze) begin
          state_d = ST_IDLE;
          if (!rst) begin
            if (ro_fault) begin
              illegal = 1'b1;
            end else begin
              csr_wr_en = mod_we;
              if (mod_we) begin
                csr_adr_wr = req_q.addr;
                csr_wrdata = new_val;
              end
              if (req_q.rd_idx != 5'd0) begin
                rd_we    = 1'b1;
                rd_waddr = req_q.rd_idx;
                rd_wdata = csr_rddata;
              end
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Scoreboard bench for csr_access_ctrl: the driver pushes the expected
// outcome of each CSR instruction, a negedge monitor collects what the DUT
// did while busy and compares when the access completes.
module tb_csr_access_ctrl;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, freeze;
  logic [2:0]  funct3;
  logic [11:0] csr_addr, csr_adr_rd, csr_adr_wr;
  logic [4:0]  rs1_idx, rd_idx, rd_waddr;
  logic [31:0] rs1_val, csr_rddata, csr_wrdata, rd_wdata;
  logic        csr_wr_en, rd_we, illegal, busy;

  always #5 clk = ~clk;

  csr_access_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .funct3(funct3), .csr_addr(csr_addr), .rs1_idx(rs1_idx), .rs1_val(rs1_val),
    .rd_idx(rd_idx), .freeze(freeze), .csr_adr_rd(csr_adr_rd),
    .csr_rddata(csr_rddata), .csr_adr_wr(csr_adr_wr), .csr_wrdata(csr_wrdata),
    .csr_wr_en(csr_wr_en), .rd_we(rd_we), .rd_waddr(rd_waddr),
    .rd_wdata(rd_wdata), .illegal(illegal), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          busy_cyc;
    bit          wr;
    logic [11:0] wa;
    logic [31:0] wd;
    bit          rdw;
    logic [4:0]  ra;
    logic [31:0] rdd;
    bit          ill;
  } exp_t;

  exp_t sb[$];

  // CSR file emulator (registered read, ignores reads while frozen) and model copy.
  logic [31:0] mem [4096];
  logic [31:0] ref_mem [4096];
  logic        mem_init;
  bit          mon_en = 0;

  function automatic logic [31:0] init_val(input int a);
    case (a)
      12'h305: return 32'h0000_0100;
      12'h300: return 32'h0000_1800;
      12'h304: return 32'h0000_0088;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int a = 0; a < 4096; a++) mem[a] <= init_val(a);
    end else if (csr_wr_en) begin
      mem[csr_adr_wr] <= csr_wrdata;
    end
    if (!freeze) csr_rddata <= mem[csr_adr_rd];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: accumulate what happened while busy, score it when busy drops.
  int          cyc, wr_n, rd_n, ill_n, wpos, rpos;
  logic [11:0] got_wa;
  logic [31:0] got_wd, got_rdd;
  logic [4:0]  got_ra;
  bit          prev_busy = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy) begin
        cyc++;
        if (csr_wr_en) begin wr_n++; got_wa = csr_adr_wr; got_wd = csr_wrdata; wpos = cyc; end
        if (rd_we) begin rd_n++; got_ra = rd_waddr; got_rdd = rd_wdata; rpos = cyc; end
        if (illegal) ill_n++;
      end else begin
        if (prev_busy) begin
          if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_underflow: access completed with no expectation queued");
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("busy_cycles", cyc, e.busy_cyc);
            check("csr_wr_count", wr_n, {31'b0, e.wr});
            if (e.wr) begin
              check("csr_adr_wr", {20'b0, got_wa}, {20'b0, e.wa});
              check("csr_wrdata", got_wd, e.wd);
              check("csr_wr_cycle", wpos, e.busy_cyc);
            end
            check("rd_we_count", rd_n, {31'b0, e.rdw});
            if (e.rdw) begin
              check("rd_waddr", {27'b0, got_ra}, {27'b0, e.ra});
              check("rd_wdata", got_rdd, e.rdd);
              check("rd_we_cycle", rpos, e.busy_cyc);
            end
            check("illegal_count", ill_n, {31'b0, e.ill});
          end
        end
        cyc = 0; wr_n = 0; rd_n = 0; ill_n = 0; wpos = 0; rpos = 0;
        check("idle_quiet", {29'b0, csr_wr_en, rd_we, illegal}, 32'd0);
        check("idle_ready", {31'b0, req_ready}, {31'b0, !freeze});
      end
      prev_busy = busy;
    end
  end

  // Driver: called just after a posedge with the DUT idle; returns likewise.
  task automatic do_req(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1,
                        input logic [31:0] v, input logic [4:0] rd,
                        input int fr1, input int fr2, input bit rst_wb);
    exp_t e;
    logic [31:0] opnd, oldv, newv;
    bit legal, dowrite;
    legal = (f3 != 3'b000) && (f3 != 3'b100);
    e = '{busy_cyc: 2 + fr1 + fr2, wr: 0, wa: 0, wd: 0, rdw: 0, ra: 0, rdd: 0, ill: 0};
    if (!legal) begin
      e.busy_cyc = 1;
      e.ill = 1;
    end else if (rst_wb) begin
      e.busy_cyc = 2 + fr1;
    end else begin
      oldv = ref_mem[a];
      opnd = f3[2] ? 32'(r1) : v;
      case (f3 & 3'b011)
        3'b001:  newv = opnd;
        3'b010:  newv = oldv | opnd;
        default: newv = oldv & ~opnd;
      endcase
      dowrite = ((f3 & 3'b011) == 3'b001) || (r1 != 0);
      if (dowrite && a >= 12'hC00) begin
        e.ill = 1;
      end else begin
        e.wr = dowrite; e.wa = a; e.wd = newv;
        e.rdw = (rd != 0); e.ra = rd; e.rdd = oldv;
        if (dowrite) ref_mem[a] = newv;
      end
    end
    sb.push_back(e);

    funct3 = f3; csr_addr = a; rs1_idx = r1; rs1_val = v; rd_idx = rd;
    req_valid = 1'b1; freeze = 1'b0;
    @(posedge clk); #1;
    // Junk on the request inputs while busy must be ignored.
    req_valid = 1'($urandom_range(0, 1));
    funct3 = 3'($urandom); csr_addr = 12'($urandom); rs1_idx = 5'($urandom);
    rs1_val = $urandom; rd_idx = 5'($urandom);
    if (!legal) begin
      @(posedge clk); #1;
    end else begin
      for (int i = 0; i < fr1; i++) begin freeze = 1'b1; @(posedge clk); #1; end
      freeze = 1'b0;
      @(posedge clk); #1;
      if (rst_wb) begin
        rst = 1'b1; #1;
        check("rstwb_no_csr_wr", {31'b0, csr_wr_en}, 32'd0);
        check("rstwb_no_rd_we", {31'b0, rd_we}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0; #1;
        check("rstwb_busy", {31'b0, busy}, 32'd0);
        check("rstwb_adr_rd", {20'b0, csr_adr_rd}, 32'd0);
        check("rstwb_outs", {csr_wr_en, rd_we, illegal, csr_adr_wr, rd_waddr}, 32'd0);
        check("rstwb_ready", {31'b0, req_ready}, 32'd1);
      end else begin
        for (int i = 0; i < fr2; i++) begin freeze = 1'b1; @(posedge clk); #1; end
        freeze = 1'b0;
        @(posedge clk); #1;
      end
    end
    req_valid = 1'b0; freeze = 1'b0;
  endtask

  // Idle gap: valid is raised only while frozen, so nothing may be accepted.
  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      freeze = 1'($urandom_range(0, 1));
      req_valid = freeze;
      @(posedge clk); #1;
    end
    req_valid = 1'b0; freeze = 1'b0;
  endtask

  localparam int NADR = 8;
  logic [11:0] adr_tab [NADR] = '{12'h305, 12'h300, 12'h304, 12'h340,
                                  12'hF14, 12'hC00, 12'h341, 12'h7C0};

  initial begin
    rst = 1'b1; mem_init = 1'b1; req_valid = 1'b0; freeze = 1'b0;
    funct3 = 0; csr_addr = 0; rs1_idx = 0; rs1_val = 0; rd_idx = 0;
    for (int a = 0; a < 4096; a++) ref_mem[a] = init_val(a);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; mem_init = 1'b0; #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_ready", {31'b0, req_ready}, 32'd1);
    check("reset_outs", {csr_wr_en, rd_we, illegal, csr_adr_rd, csr_adr_wr, rd_waddr}, 32'd0);
    check("reset_data", csr_wrdata | rd_wdata, 32'd0);
    mon_en = 1;

    // Directed cases.
    do_req(3'b001, 12'h305, 5'd2, 32'h0000_1004, 5'd5, 0, 0, 0); // CSRRW mtvec
    do_req(3'b010, 12'h300, 5'd0, 32'hFFFF_FFFF, 5'd3, 0, 0, 0); // CSRRS x0, no write
    do_req(3'b111, 12'h304, 5'h1F, 32'h0, 5'd0, 0, 0, 0);        // CSRRCI zimm=1F, rd=0
    do_req(3'b001, 12'hF14, 5'd4, 32'h1234, 5'd7, 0, 0, 0);      // read-only CSR
    do_req(3'b001, 12'h340, 5'd6, 32'hCAFE_F00D, 5'd9, 2, 0, 0); // freeze 2 in RD
    do_req(3'b001, 12'h341, 5'd6, 32'hDEAD_BEEF, 5'd8, 0, 0, 1); // reset in WB
    do_req(3'b000, 12'h305, 5'd1, 32'h1, 5'd1, 0, 0, 0);         // illegal funct3
    do_req(3'b100, 12'h305, 5'd1, 32'h1, 5'd1, 0, 0, 0);
    do_req(3'b110, 12'hC00, 5'd0, 32'h0, 5'd4, 0, 1, 0);         // RSI x0 on RO: legal read
    do_req(3'b011, 12'h305, 5'd3, 32'h0000_0004, 5'd10, 1, 2, 0); // RC, back to back

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      logic [2:0] f3;
      logic [4:0] r1, rd;
      int fr1, fr2;
      bit rw;
      f3  = 3'($urandom_range(0, 7));
      r1  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      fr1 = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      fr2 = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      rw  = ($urandom_range(0, 15) == 0);
      if (rw) fr2 = 0;
      do_req(f3, adr_tab[$urandom_range(0, NADR - 1)], r1, $urandom, rd, fr1, fr2, rw);
      idle_gap($urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
